// File: rtl/bus_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_uart_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter:
//                register word offsets, frame FSM state encoding, STATUS
//                bit positions and a STATUS count-field helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_uart_pkg;

    // Word offsets inside the 16-byte register window (address[3:2]).
    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;
    localparam logic [1:0] UART_RSVD    = 2'd3;

    // Frame state machine encoding.
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_tx_state_t;

    // STATUS register layout.
    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 4;

    // The count field is only four bits wide; larger FIFOs saturate at 15.
    function automatic logic [STATUS_COUNT_W-1:0] status_count(input logic [31:0] cnt);
        if (cnt > 32'd15) begin
            return 4'hF;
        end
        return cnt[STATUS_COUNT_W-1:0];
    endfunction

endpackage : bus_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous first-word-fall-through FIFO holding bytes
//                waiting for transmission.
//  Ports       : clock/reset      clock, asynchronous active-high reset
//                push/data_in     write strobe and data (ignored when full)
//                pop/data_out     read strobe and head entry (always visible)
//                full/empty/count occupancy flags and entry count
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // Flags come from the pre-edge count, so a push into a full FIFO is
    // dropped even if a pop happens on the same edge.
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide and wrap modulo DEPTH by overflow.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/bus_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bus_uart_tx
//  Description : Bus-responder UART transmitter. Bytes written to TXDATA are
//                queued in a FIFO and sent as 8N1 frames on uart_tx at a
//                bit time of DIVISOR+1 clock cycles.
//  Ports       : clock/reset    clock, asynchronous active-high reset
//                address        byte address from the core
//                write_data     store data
//                byte_enable    byte lanes of the access
//                read_enable    load strobe
//                write_enable   store strobe
//                read_data      combinational load data
//                uart_tx        serial line, idle high
//  Registers   : 0x0 TXDATA (WO), 0x4 STATUS (RO), 0x8 DIVISOR (RW),
//                0xC reserved
//  Revision    : 1.0  initial release
// ============================================================================
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        uart_tx
);

    localparam int CW = $clog2(DEPTH) + 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       hit;
    logic [1:0] offset;
    logic       wr_hit;
    logic       txdata_push;
    logic       div_write;
    logic       unused_bits;

    assign hit         = (address[31:4] == BASE_ADDR[31:4]);
    assign offset      = address[3:2];
    assign wr_hit      = write_enable && hit;
    assign txdata_push = wr_hit && (offset == UART_TXDATA) && byte_enable[0];
    assign div_write   = wr_hit && (offset == UART_DIVISOR);

    // Bits of the bus that no register ever looks at.
    assign unused_bits = ^{address[1:0], write_data[31:16], byte_enable[3:2]};

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (txdata_push),
        .data_in  (write_data[7:0]),
        .pop      (fifo_pop),
        .data_out (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // ------------------------------------------------------------------
    // DIVISOR register, byte lanes 0 and 1 independently writable
    // ------------------------------------------------------------------
    logic [15:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (div_write) begin
            if (byte_enable[0]) begin
                div_d[7:0] = write_data[7:0];
            end
            if (byte_enable[1]) begin
                div_d[15:8] = write_data[15:8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    uart_tx_state_t state_q,   state_d;
    logic [15:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q,   shift_d;
    logic           tx_q,      tx_d;
    logic           bit_done;

    // The bit counter is loaded with DIVISOR at every bit boundary and counts
    // down to zero, giving DIVISOR+1 cycles per bit. A DIVISOR change only
    // takes effect at the next reload.
    assign bit_done = (bit_cnt_q == 16'd0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    bit_cnt_d = div_q;
                    tx_d      = 1'b0;
                    state_d   = UART_START;
                end
            end

            UART_START: begin
                if (bit_done) begin
                    bit_cnt_d = div_q;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = UART_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end

            UART_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = div_q;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
                    end else begin
                        // The line is registered, so present the bit that the
                        // shift will bring into position 0.
                        tx_d = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end

            UART_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_dout;
                        bit_cnt_d = div_q;
                        tx_d      = 1'b0;
                        state_d   = UART_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = UART_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = UART_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= UART_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign uart_tx = tx_q;

    // ------------------------------------------------------------------
    // Read mux (combinational, no side effects)
    // ------------------------------------------------------------------
    logic [31:0] status_word;

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_BUSY_BIT]  = (state_q != UART_IDLE);
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = status_count(32'(fifo_count));
    end

    always_comb begin
        read_data = '0;
        if (read_enable && hit) begin
            case (offset)
                UART_STATUS:  read_data = status_word;
                UART_DIVISOR: read_data = {16'h0000, div_q};
                default:      read_data = '0;
            endcase
        end
    end

endmodule : bus_uart_tx
`default_nettype wire

// File: tb/tb_bus_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_uart_tx
//  Description : Directed self-checking bench for bus_uart_tx. Expected
//                register values and line levels are hand-derived 8N1
//                frames and STATUS encodings.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_uart_tx;

    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam logic [31:0] A_TXDATA = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_DIV    = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  byte_enable = '0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] read_data;
    logic        uart_tx;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd_main;
    logic [31:0] rd_busy;

    logic [7:0] burst [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C,
                              8'hC3, 8'h5A, 8'h96, 8'h69};
    logic [7:0] stall [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                              8'h66, 8'h88, 8'h99, 8'hAA};

    bus_uart_tx #(
        .BASE_ADDR   (BASE),
        .DEPTH       (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write_data   (write_data),
        .byte_enable  (byte_enable),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .read_data    (read_data),
        .uart_tx      (uart_tx)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Frame bit i: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // Write takes effect on the posedge this task waits for.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clock);
        address      = addr;
        write_data   = data;
        byte_enable  = be;
        write_enable = 1'b1;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        byte_enable  = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clock);
        address     = addr;
        read_enable = 1'b1;
        #1;
        data        = read_data;
        read_enable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check_eq(tag, d, exp);
    endtask

    // Checks every cycle of a frame, starting at the next negedge.
    task automatic check_frame(input logic [7:0] b, input int div);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c <= div; c++) begin
                @(negedge clock);
                check_eq("frame_bit", {31'b0, uart_tx}, {31'b0, frame_bit(b, i)});
            end
        end
    endtask

    task automatic idle_check(input string tag, input int ncycles);
        int bad = 0;
        for (int i = 0; i < ncycles; i++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        // ---------------- reset and idle ----------------
        repeat (3) @(negedge clock);
        check_eq("rst_tx", {31'b0, uart_tx}, 32'h1);
        reset = 1'b0;
        address = A_STATUS;
        #1;
        check_eq("rd_no_enable", read_data, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0000_0002);
        read_check("rst_div", A_DIV, 32'd433);
        idle_check("idle_line", 100);

        // ---------------- single byte, DIVISOR=3 ----------------
        bus_write(A_DIV, 32'h0000_0003, 4'b0011);
        read_check("div3", A_DIV, 32'h3);
        bus_write(A_TXDATA, 32'h0000_00A5, 4'b0001);
        @(negedge clock);
        check_eq("a5_prestart", {31'b0, uart_tx}, 32'h1);
        check_frame(8'hA5, 3);
        @(negedge clock);
        check_eq("a5_after", {31'b0, uart_tx}, 32'h1);
        read_check("a5_status", A_STATUS, 32'h0000_0002);

        // ---------------- 9 back-to-back bytes, DIVISOR=0 ----------------
        bus_write(A_DIV, 32'h0, 4'b0011);
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    bus_write(A_TXDATA, {24'h0, burst[i]}, 4'b0001);
                end
                for (int j = 0; j < 80; j++) begin
                    bus_read(A_STATUS, rd_busy);
                    check_eq("burst_busy", {31'b0, rd_busy[2]}, 32'h1);
                end
            end
            begin
                @(negedge clock);
                @(negedge clock);
                check_eq("burst_prestart", {31'b0, uart_tx}, 32'h1);
                for (int f = 0; f < 9; f++) begin
                    check_frame(burst[f], 0);
                end
            end
        join
        read_check("burst_done_status", A_STATUS, 32'h0000_0002);

        // ---------------- stalled FIFO fill and dropped write ----------------
        bus_write(A_DIV, 32'h0000_00FF, 4'b0011);
        for (int i = 0; i < 9; i++) begin
            bus_write(A_TXDATA, {24'h0, stall[i]}, 4'b0001);
        end
        // count=8, full, busy
        read_check("stall_full", A_STATUS, 32'h0000_0085);
        bus_write(A_TXDATA, 32'h0000_0077, 4'b0001);
        read_check("drop_status", A_STATUS, 32'h0000_0085);
        bus_write(A_DIV, 32'h0, 4'b0011);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (uart_tx !== 1'b1 && waited < 400);
        // First high level is data bit 0 of 0x11.
        check_eq("stall_release", {31'b0, uart_tx}, 32'h1);
        for (int i = 2; i < 10; i++) begin
            @(negedge clock);
            check_eq("stall_first", {31'b0, uart_tx}, {31'b0, frame_bit(stall[0], i)});
        end
        for (int f = 1; f < 9; f++) begin
            check_frame(stall[f], 0);
        end
        idle_check("no_0x77", 30);
        read_check("stall_done_status", A_STATUS, 32'h0000_0002);

        // ---------------- DIVISOR lanes and decode ----------------
        bus_write(A_DIV, 32'h0000_0005, 4'b0011);
        read_check("div5", A_DIV, 32'h5);
        bus_write(A_DIV, 32'h0000_1234, 4'b0001);
        read_check("div_lane0", A_DIV, 32'h0000_0034);
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'b1111);
        bus_write(32'h9000_0008, 32'h0000_FFFF, 4'b0011);
        read_check("div_untouched", A_DIV, 32'h0000_0034);
        read_check("rsvd_read", A_RSVD, 32'h0);
        read_check("miss_read", 32'h9000_0004, 32'h0);
        read_check("txdata_read", A_TXDATA, 32'h0);
        idle_check("no_stray_tx", 20);

        // ---------------- reset mid-frame ----------------
        bus_write(A_DIV, 32'h3, 4'b0011);
        bus_write(A_TXDATA, 32'h0000_0000, 4'b0001);
        bus_write(A_TXDATA, 32'h0000_0055, 4'b0001);
        repeat (8) @(negedge clock);
        check_eq("mid_data_low", {31'b0, uart_tx}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("reset_abort", {31'b0, uart_tx}, 32'h1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        read_check("post_reset_status", A_STATUS, 32'h0000_0002);
        read_check("post_reset_div", A_DIV, 32'd433);
        idle_check("post_reset_idle", 60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bus_uart_tx
`default_nettype wire
